// File: rtl/fifo_reader.sv
// Pulls bytes from an 8-bit FIFO read port into a 2-entry output buffer.
// The output side uses a valid/ready handshake.
module fifo_reader (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic       fifo_rd_ack,
    input  logic [7:0] fifo_d_in,
    output logic       fifo_rd_en,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [7:0] rd_count,
    output logic       rd_err,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

    state_t     state;
    logic [1:0] occ;
    logic       inflight;
    logic       head;
    logic [7:0] mem [2];

    logic       pop, push, miss, tail;
    logic [2:0] committed;

    assign pop       = out_valid & out_ready;
    assign push      = inflight & fifo_rd_ack;
    assign miss      = inflight & ~fifo_rd_ack;
    assign tail      = head ^ occ[0];
    // Slots already spoken for after this cycle's pop; an in-flight read owns one.
    assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = (state == RUN) & ~fifo_empty & (committed < 3'd2);
    assign out_valid  = (occ != 2'd0);
    assign out_data   = mem[head];
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= 1'b0;
            mem[0]   <= 8'h00;
            mem[1]   <= 8'h00;
            rd_count <= 8'h00;
            rd_err   <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;

            if (push) mem[tail] <= fifo_d_in;
            if (pop)  head <= ~head;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase

            if (state == IDLE && enable) begin
                rd_count <= 8'h00;
                rd_err   <= 1'b0;
            end else begin
                if (push) rd_count <= rd_count + 8'd1;
                if (miss) rd_err <= 1'b1;
            end

            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= STOP;
                STOP: begin
                    if (enable)         state <= RUN;
                    else if (!inflight) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a FIFO model feeds acks, a scoreboard checks the output stream.
module tb_fifo_reader;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_ack = 1'b0;
    logic [7:0] fifo_d_in = 8'h00;
    logic       out_ready = 1'b0;
    logic       fifo_rd_en, out_valid, rd_err, busy;
    logic [7:0] out_data, rd_count;

    fifo_reader dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_ack(fifo_rd_ack), .fifo_d_in(fifo_d_in), .fifo_rd_en(fifo_rd_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rd_count(rd_count), .rd_err(rd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] src[$];
    logic [7:0] exp_q[$];
    int  errs = 0, checks = 0;
    int  cyc = 0, rd_cnt = 0, deliv = 0, gap_cnt = 0;
    int  first_rd = -1, first_ov = -1, first_dv = -1, last_dv = -1;
    bit  ack_on = 1'b1, spur = 1'b0, gap_mon = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // FIFO model: a read seen in cycle t is acked with data in cycle t+1.
    initial begin : feeder
        logic       en_s;
        logic [7:0] w;
        forever begin
            @(negedge clk);
            en_s = fifo_rd_en;
            @(posedge clk);
            #1;
            fifo_rd_ack = 1'b0;
            fifo_d_in   = 8'h00;
            if (reset_n) begin
                if (en_s && src.size() > 0) begin
                    w = src.pop_front();
                    if (ack_on) begin
                        fifo_rd_ack = 1'b1;
                        fifo_d_in   = w;
                        exp_q.push_back(w);
                    end
                end else if (!en_s && spur) begin
                    fifo_rd_ack = 1'b1;
                    fifo_d_in   = 8'hEE;
                end
            end
            fifo_empty = (src.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (gap_mon && first_rd >= 0 && busy && !fifo_empty && !fifo_rd_en) gap_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
            else begin
                check("sb_data", out_data, exp_q.pop_front());
                deliv++;
                if (first_dv < 0) first_dv = cyc;
                last_dv = cyc;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; enable = 1'b0; out_ready = 1'b0; ack_on = 1'b1; spur = 1'b0;
        repeat (2) @(negedge clk);
        src.delete(); exp_q.delete();
        first_rd = -1; first_ov = -1; first_dv = -1; last_dv = -1;
        rd_cnt = 0; deliv = 0; gap_cnt = 0;
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input int max);
        int  n = 0;
        bit  done;
        do begin
            @(negedge clk);
            n++;
            done = (src.size() == 0) && (exp_q.size() == 0) && !fifo_rd_en && !fifo_rd_ack && !out_valid;
        end while (!done && n < max);
        check("drain_done", done, 1);
    endtask

    task automatic wait_rd_en(input int max);
        int n = 0;
        do begin @(negedge clk); n++; end while (!fifo_rd_en && n < max);
        check("rd_en_seen", fifo_rd_en, 1);
    endtask

    initial begin
        // reset state
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_count", rd_count, 0);
        check("rst_err", rd_err, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        do_reset();

        // three words, streaming
        src = '{8'hA1, 8'hB2, 8'hC3};
        out_ready = 1'b1; enable = 1'b1;
        wait_drain(50);
        check("t1_count", rd_count, 3);
        check("t1_latency", first_ov - first_rd, 2);
        check("t1_consec", last_dv - first_dv, 2);
        check("t1_deliv", deliv, 3);
        check("t1_reads", rd_cnt, 3);

        // backpressure: buffer fills to 2 then reads stop
        do_reset();
        src = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        enable = 1'b1;
        repeat (10) @(negedge clk);
        check("t2_reads", rd_cnt, 2);
        check("t2_rd_en", fifo_rd_en, 0);
        check("t2_valid", out_valid, 1);
        check("t2_head", out_data, 8'h10);
        repeat (3) @(negedge clk);
        check("t2_hold", out_data, 8'h10);
        out_ready = 1'b1;
        wait_drain(50);
        check("t2_count", rd_count, 5);
        check("t2_deliv", deliv, 5);

        // enable dropped with a read in flight
        do_reset();
        src = '{8'h5A, 8'h5B, 8'h5C};
        out_ready = 1'b1; enable = 1'b1;
        wait_rd_en(20);
        enable = 1'b0;
        @(negedge clk);
        check("t3_stop_busy", busy, 1);
        repeat (6) @(negedge clk);
        check("t3_idle", busy, 0);
        check("t3_deliv", deliv, 1);
        check("t3_reads", rd_cnt, 1);
        check("t3_count", rd_count, 1);
        check("t3_rd_en", fifo_rd_en, 0);
        src.delete();

        // missing ack sets rd_err; restart clears it
        do_reset();
        src = '{8'h11, 8'h22};
        out_ready = 1'b1; enable = 1'b1;
        wait_drain(50);
        check("t4_count_pre", rd_count, 2);
        ack_on = 1'b0;
        src.push_back(8'h33);
        wait_rd_en(20);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_err", rd_err, 1);
        check("t4_count_hold", rd_count, 2);
        check("t4_idle", busy, 0);
        check("t4_no_word", out_valid, 0);
        ack_on = 1'b1; enable = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_err_clr", rd_err, 0);
        check("t4_count_clr", rd_count, 0);
        check("t4_run", busy, 1);
        // stray ack with nothing in flight
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_spur_count", rd_count, 0);
        check("t4_spur_valid", out_valid, 0);
        enable = 1'b0;

        // 257-word stream, count wraps
        do_reset();
        for (int i = 0; i < 257; i++) src.push_back(8'(i));
        out_ready = 1'b1; gap_mon = 1'b1; enable = 1'b1;
        wait_drain(400);
        gap_mon = 1'b0;
        check("t5_count_wrap", rd_count, 8'h01);
        check("t5_reads", rd_cnt, 257);
        check("t5_deliv", deliv, 257);
        check("t5_gaps", gap_cnt, 0);

        // async reset with a full buffer
        do_reset();
        src = '{8'h71, 8'h72, 8'h73, 8'h74};
        enable = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_full", out_valid, 1);
        check("t6_count_pre", rd_count, 2);
        reset_n = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_data", out_data, 8'h00);
        check("t6_busy", busy, 0);
        check("t6_rd_en", fifo_rd_en, 0);
        check("t6_count", rd_count, 0);
        @(negedge clk);
        src.delete(); exp_q.delete();
        enable = 1'b0; spur = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_ack_ign_count", rd_count, 0);
        check("t6_ack_ign_valid", out_valid, 0);

        check("sb_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
